memif_rr_arbiter: RTL and testbench

MEMIF_RR_ARBITER -- requirements
Module: memif_rr_arbiter

---
 rtl/memif_rr_arbiter.sv | 113 +++++++++++
 tb/tb_memif_rr_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memif_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters.
// Out-of-range requests are granted but answered locally with SLVERR.
module memif_rr_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [63:0] MEM_BASE = '0,
  parameter int unsigned MEM_SIZE = 32
) (
  input  logic                              clk_i,
  input  logic                              arst_ni,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ-1:0]                req_we_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_wdata_i,
  input  logic [NUM_REQ-1:0][DATA_W/8-1:0]  req_wstrb_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [DATA_W-1:0]                 rsp_rdata_o,
  output logic [1:0]                        rsp_resp_o,
  output logic                              mem_en_o,
  output logic                              mem_we_o,
  output logic [MEM_SIZE-1:0]               mem_addr_o,
  output logic [DATA_W-1:0]                 mem_wdata_o,
  output logic [DATA_W/8-1:0]               mem_wstrb_o,
  input  logic [DATA_W-1:0]                 mem_rdata_i,
  input  logic [1:0]                        mem_resp_i
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [63:0] MEM_END =
    MEM_BASE + (64'd1 << MEM_SIZE);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] idx_q;
  logic             pend_q;
  logic             err_q;

  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             grant;
  logic [63:0]      addr_abs;
  logic             in_range;
  logic [NUM_REQ-1:0] one_hot;

  // Search starts just after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign grant    = found & arst_ni;
  assign addr_abs = 64'(req_addr_i[win]);
  assign in_range = (addr_abs >= MEM_BASE)
                  && (addr_abs < MEM_END);
  assign one_hot  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  assign req_ready_o = grant ? (one_hot << win) : '0;

  assign mem_en_o    = grant & in_range;
  assign mem_we_o    = mem_en_o & req_we_i[win];
  assign mem_addr_o  = grant
                     ? MEM_SIZE'(addr_abs - MEM_BASE)
                     : '0;
  assign mem_wdata_o = grant ? req_wdata_i[win] : '0;
  assign mem_wstrb_o = grant
                     ? req_wstrb_i[win]
                     : {STRB_W{1'b0}};

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ptr_q  <= IDX_W'(NUM_REQ - 1);
      pend_q <= 1'b0;
      idx_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= grant;
      if (grant) begin
        ptr_q <= win;
        idx_q <= win;
        err_q <= !in_range;
      end
    end
  end

  // Memory data arrives one cycle after the grant, aligned with pend_q.
  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    rsp_resp_o  = 2'b00;
    if (pend_q) begin
      rsp_valid_o = one_hot << idx_q;
      if (err_q) begin
        rsp_resp_o = RESP_SLVERR;
      end else begin
        rsp_rdata_o = mem_rdata_i;
        rsp_resp_o  = mem_resp_i;
      end
    end
  end

endmodule

// File: tb/tb_memif_rr_arbiter.sv
// Scoreboard bench for memif_rr_arbiter: directed corner cases,
// then randomized traffic against a transaction-level model.
module tb_memif_rr_arbiter;

  localparam int          N    = 4;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam logic [31:0] B32  = 32'h8000_0000;
  localparam int          MSZ  = 12;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  logic clk;
  logic arst_ni;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         req_we;
  logic [N-1:0][31:0]   req_addr;
  logic [N-1:0][31:0]   req_wdata;
  logic [N-1:0][3:0]    req_wstrb;
  logic [N-1:0]         rsp_valid;
  logic [31:0]          rsp_rdata;
  logic [1:0]           rsp_resp;
  logic                 mem_en;
  logic                 mem_we;
  logic [MSZ-1:0]       mem_addr;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_wstrb;
  logic [31:0]          mem_rdata;
  logic [1:0]           mem_resp;

  memif_rr_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (32),
    .DATA_W  (32),
    .MEM_BASE(BASE),
    .MEM_SIZE(MSZ)
  ) dut (
    .clk_i      (clk),
    .arst_ni    (arst_ni),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .rsp_resp_o (rsp_resp),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_wstrb_o(mem_wstrb),
    .mem_rdata_i(mem_rdata),
    .mem_resp_i (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  exp_t sb[$];

  logic [N-1:0]       s_valid;
  logic [N-1:0]       s_we;
  logic [N-1:0][31:0] s_addr;
  logic [N-1:0][31:0] s_wdata;
  logic [N-1:0][3:0]  s_wstrb;
  logic [1:0]         next_resp;
  bit                 force_resp = 0;
  bit                 rnd = 0;
  bit                 done = 0;
  int                 m_ptr = N - 1;
  logic [31:0]        m_mem [1024];
  logic [31:0]        r_mem [1024];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] d,
    input logic [3:0]  s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Round-robin rule: first valid index after the last winner.
  function automatic int rr_pick(input int ptr,
                                 input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0: return B32 - 32'($urandom_range(1, 64));
      1: return B32 + 32'h1000;
      2: return B32 + 32'h1000 + 32'($urandom_range(0, 255));
      3: return B32 + 32'hffc;
      default: return B32 + (32'($urandom_range(0, 1023)) << 2);
    endcase
  endfunction

  task automatic new_req(input int i);
    s_valid[i] = 1'b1;
    s_we[i]    = 1'($urandom);
    s_addr[i]  = rnd_addr();
    s_wdata[i] = $urandom;
    s_wstrb[i] = 4'($urandom);
  endtask

  // Behavioural memory on the far side of the DUT.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        r_mem[mem_addr[11:2]] <=
          merge(r_mem[mem_addr[11:2]], mem_wdata, mem_wstrb);
      mem_rdata <= mem_we
        ? merge(r_mem[mem_addr[11:2]], mem_wdata, mem_wstrb)
        : r_mem[mem_addr[11:2]];
      mem_resp  <= next_resp;
    end else begin
      mem_rdata <= $urandom;
      mem_resp  <= 2'($urandom);
    end
  end

  task automatic cycle(input bit rst_low, input int exp_g);
    int               g;
    int               w;
    longint unsigned  a;
    bit               inr;
    exp_t             e;
    @(posedge clk);
    #1;
    if (rst_low) begin
      sb.delete();
      m_ptr = N - 1;
    end
    arst_ni   = !rst_low;
    req_valid = s_valid;
    req_we    = s_we;
    req_addr  = s_addr;
    req_wdata = s_wdata;
    req_wstrb = s_wstrb;
    next_resp = force_resp ? 2'b11 : 2'($urandom);
    @(negedge clk);
    g = rst_low ? -1 : rr_pick(m_ptr, s_valid);
    chk("req_ready", 64'(req_ready),
        g < 0 ? 64'd0 : (64'd1 << g));
    if (exp_g != -2)
      chk("grant_order", 64'(req_ready),
          exp_g < 0 ? 64'd0 : (64'd1 << exp_g));
    if (g < 0) begin
      chk("mem_en_idle", 64'(mem_en), 64'd0);
    end else begin
      a   = 64'(s_addr[g]);
      inr = (a >= BASE) && (a < BASE + 64'd4096);
      chk("mem_en", 64'(mem_en), 64'(inr));
      if (inr) begin
        w = int'((a - BASE) >> 2);
        chk("mem_we", 64'(mem_we), 64'(s_we[g]));
        chk("mem_addr", 64'(mem_addr), (a - BASE) & 64'hfff);
        chk("mem_wdata", 64'(mem_wdata), 64'(s_wdata[g]));
        chk("mem_wstrb", 64'(mem_wstrb), 64'(s_wstrb[g]));
        if (s_we[g])
          m_mem[w] = merge(m_mem[w], s_wdata[g], s_wstrb[g]);
        e.rdata = m_mem[w];
        e.resp  = next_resp;
      end else begin
        e.rdata = '0;
        e.resp  = 2'b10;
      end
      e.idx = g;
      sb.push_back(e);
      m_ptr = g;
      if (rnd) s_valid[g] = 1'b0;
    end
    if (rnd)
      for (int i = 0; i < N; i++)
        if (!s_valid[i] && $urandom_range(0, 1) == 1)
          new_req(i);
  endtask

  // Monitor: pop one expectation per response, else demand idle outputs.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'd1 << e.idx);
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
      end else begin
        chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
        chk("rsp_rdata_idle", 64'(rsp_rdata), 64'd0);
        chk("rsp_resp_idle", 64'(rsp_resp), 64'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      m_mem[i] = 32'h1357_9bdf ^ (32'(i) * 32'h0101_0101);
      r_mem[i] = 32'h1357_9bdf ^ (32'(i) * 32'h0101_0101);
    end
    arst_ni   = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    next_resp = 2'b00;
    s_valid   = '1;
    s_we      = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    for (int i = 0; i < N; i++)
      s_addr[i] = B32 + 32'(16 * (i + 1));

    cycle(1, -1);
    cycle(1, -1);

    s_valid = 4'b0011;
    cycle(0, 0);
    cycle(0, 1);
    cycle(0, 0);
    cycle(0, 1);

    s_valid    = 4'b0010;
    s_we[1]    = 1'b1;
    s_addr[1]  = B32 + 32'h8;
    s_wdata[1] = 32'hDEAD_BEEF;
    s_wstrb[1] = 4'hF;
    cycle(0, 1);

    s_valid   = 4'b0001;
    s_we[0]   = 1'b0;
    s_addr[0] = B32 + 32'h1000;
    cycle(0, 0);

    s_valid   = 4'b0100;
    s_addr[0] = B32 + 32'h40;
    s_we[1]   = 1'b0;
    cycle(0, 2);
    s_valid = 4'b1111;
    cycle(0, 3);
    cycle(0, 0);
    cycle(0, 1);
    cycle(0, 2);

    s_valid    = 4'b1000;
    s_addr[3]  = B32 + 32'h8;
    force_resp = 1;
    cycle(0, 3);
    force_resp = 0;

    s_valid = 4'b1111;
    cycle(0, 0);
    cycle(1, -1);
    cycle(0, 0);

    rnd     = 1;
    s_valid = '0;
    for (int c = 0; c < 3000; c++)
      cycle(0, -2);

    rnd     = 0;
    s_valid = '0;
    cycle(0, -1);
    cycle(0, -1);
    done = 1;
    @(posedge clk);
    @(posedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
